mem_port_arbiter: RTL

- Shares the core's single memory port between two requesters: the instruction-fetch requester (if_) and the load/store requester (dm_).
- Sits between the multicycle control unit/datapath and the unified instruction/data memory.
- Serialises accesses through a registered state machine, holding one transaction at a time to completion.
- Arbitrates round-robin when both requesters ask in the same cycle, and returns read data with a one-cycle done pulse.

---
 rtl/mem_port_arbiter.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one memory port between the instruction-fetch requester (if_*) and
// the load/store requester (dm_*). One transaction is held on the port until
// the memory acknowledges it. The block then spends one RESP cycle pulsing
// the requester's done, and returns to IDLE to arbitrate again. Simultaneous
// requests are granted round-robin: the requester that did not own the port
// last wins. Every output is a register.
//
// Optional feature (compile-time macro ARB_TIMEOUT_EN):
//   Each access is bounded to TIMEOUT_CYC cycles. On expiry the access ends
//   with done=1, err=1 and rdata=0. When the macro is undefined there is no
//   counter, err stays 0 and an access waits for mem_ack indefinitely.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   if_req/if_addr    fetch request (level, held until if_done) and address
//   if_gnt/if_done    fetch owns the port / one-cycle completion pulse
//   if_rdata          fetched word
//   dm_req/dm_we      data request (level, held until dm_done), 1 = store
//   dm_addr/dm_wdata  data address and store data
//   dm_gnt/dm_done    data access owns the port / one-cycle completion pulse
//   dm_rdata          load data (unchanged by stores)
//   mem_req/mem_we    memory request (held until mem_ack), write enable
//   mem_addr/mem_wdata  memory address and write data
//   mem_ack/mem_rdata memory completion, read data valid with mem_ack
//   err               timeout flag, pulses together with done
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_done,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, ACC_IF, ACC_DM, RESP} state_t;
  typedef enum logic {OWN_IF, OWN_DM} owner_t;

  state_t state;
  owner_t last_owner;

  // DM wins when it asks alone, or on a tie when IF owned the port last.
  logic pick_dm;
  assign pick_dm = dm_req && (!if_req || last_owner == OWN_IF);

  // tmo_hit: the access must end this cycle because its time budget is spent.
  logic tmo_hit;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYC);

  logic [CNT_W-1:0] tmo_cnt;

  // The limit is "reached" on the edge that would bring the count to
  // TIMEOUT_CYC, so an access holds mem_req for exactly TIMEOUT_CYC cycles.
  // An ack in that same cycle takes priority.
  assign tmo_hit = (state == ACC_IF || state == ACC_DM) && !mem_ack &&
                   (tmo_cnt + CNT_W'(1) == CNT_LIMIT);

  // Cleared in IDLE, so it always starts at zero on entry to an access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (state == ACC_IF || state == ACC_DM) begin
      tmo_cnt <= tmo_cnt + CNT_W'(1);
    end else begin
      tmo_cnt <= '0;
    end
  end
`else
  assign tmo_hit = 1'b0;

  // The timeout length has no function in this build.
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_CYC > 0);
`endif

  // NOTE: every register here is assigned with <= so that all updates in a
  // cycle see the pre-edge values; mixing in blocking writes would make the
  // result depend on statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_owner <= OWN_IF;
      if_gnt     <= 1'b0;
      if_done    <= 1'b0;
      if_rdata   <= '0;
      dm_gnt     <= 1'b0;
      dm_done    <= 1'b0;
      dm_rdata   <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      err        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // mem_ack is ignored here: no access is outstanding.
          if (pick_dm) begin
            state      <= ACC_DM;
            last_owner <= OWN_DM;
            dm_gnt     <= 1'b1;
            mem_req    <= 1'b1;
            mem_we     <= dm_we;
            mem_addr   <= dm_addr;
            mem_wdata  <= dm_wdata;
          end else if (if_req) begin
            state      <= ACC_IF;
            last_owner <= OWN_IF;
            if_gnt     <= 1'b1;
            mem_req    <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= if_addr;
            mem_wdata  <= '0;
          end
        end

        ACC_IF, ACC_DM: begin
          // mem_* outputs hold their values until the access ends.
          if (mem_ack || tmo_hit) begin
            state   <= RESP;
            mem_req <= 1'b0;
            if_gnt  <= 1'b0;
            dm_gnt  <= 1'b0;
            err     <= tmo_hit;
            if (state == ACC_IF) begin
              if_done  <= 1'b1;
              if_rdata <= tmo_hit ? '0 : mem_rdata;
            end else begin
              dm_done <= 1'b1;
              if (tmo_hit) begin
                dm_rdata <= '0;
              end else if (!mem_we) begin
                dm_rdata <= mem_rdata;
              end
            end
          end
        end

        RESP: begin
          // Requests are not looked at here; the owner drops req this cycle.
          if_done <= 1'b0;
          dm_done <= 1'b0;
          err     <= 1'b0;
          state   <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
